// File: rtl/riscv_multicycle_mem_core.sv
// Multicycle RV32 subset core (IF/ID/EX/MEM/WB/HALT) with external instruction and data
// memories behind request/valid handshakes that tolerate any number of wait states.
// Latency: branch 3, ALU/jal/sw 4, lw 5 cycles with zero-wait memories; +1 per memory wait cycle.
// Backpressure: IF and MEM hold the request and its address/data stable until the memory
//   answers with *_valid. There is no other stall source.
// Ports:
//   clk, rst_n                            clock, async active-low reset
//   imem_req/imem_addr/imem_rdata/imem_valid   instruction fetch handshake (addr = PC)
//   dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_rdata/dmem_valid   load/store handshake
//   done (sticky halt), illegal (1-cycle EX pulse), clock_count, instr_count (saturating)
module riscv_multicycle_mem_core #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          CNT_W     = 16,
  parameter int          REG_INIT  = 1,
  parameter logic [31:0] HALT_WORD = 32'h1111_1111
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_valid,
  output logic              done,
  output logic              illegal,
  output logic [CNT_W-1:0]  clock_count,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STOR = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t      state, state_nxt;
  logic [31:0] pc, ir, a_q, b_q, alu_out, mdr;
  logic [31:0] regs [0:31];

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, pc_ir;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_u  = {ir[31:12], 12'b0};
  // PC was already advanced past the instruction in IR during fetch.
  assign pc_ir  = pc - 32'd4;

  // Instruction decode / execute (meaningful only while IR holds a fetched instruction).
  logic        ex_legal, ex_mem, ex_store, ex_branch, ex_taken, ex_jal;
  logic [31:0] ex_val;

  always_comb begin
    ex_legal  = 1'b0;
    ex_mem    = 1'b0;
    ex_store  = 1'b0;
    ex_branch = 1'b0;
    ex_taken  = 1'b0;
    ex_jal    = 1'b0;
    ex_val    = '0;
    case (opcode)
      OP_R: if (funct3 == 3'b000) begin
        case (funct7)
          7'b0000000: begin ex_legal = 1'b1; ex_val = a_q + b_q; end
          7'b0100000: begin ex_legal = 1'b1; ex_val = a_q - b_q; end
          7'b0000001: begin ex_legal = 1'b1; ex_val = a_q * b_q; end
          default: ;
        endcase
      end
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          ex_legal = 1'b1;
          ex_val   = a_q + imm_i;
        end else if (funct3 == 3'b001 && funct7 == 7'b0) begin
          ex_legal = 1'b1;
          ex_val   = a_q << rs2;
        end
      end
      OP_LUI: begin ex_legal = 1'b1; ex_val = imm_u; end
      OP_LOAD: if (funct3 == 3'b010) begin
        ex_legal = 1'b1; ex_mem = 1'b1; ex_val = a_q + imm_i;
      end
      OP_STOR: if (funct3 == 3'b010) begin
        ex_legal = 1'b1; ex_mem = 1'b1; ex_store = 1'b1; ex_val = a_q + imm_s;
      end
      OP_BR: begin
        ex_legal  = 1'b1;
        ex_branch = 1'b1;
        case (funct3)
          3'b000:  ex_taken = (a_q == b_q);
          3'b001:  ex_taken = (a_q != b_q);
          3'b100:  ex_taken = ($signed(a_q) < $signed(b_q));
          3'b101:  ex_taken = ($signed(a_q) >= $signed(b_q));
          default: begin ex_legal = 1'b0; ex_branch = 1'b0; end
        endcase
      end
      OP_JAL: begin ex_legal = 1'b1; ex_jal = 1'b1; ex_val = pc; end
      default: ;
    endcase
  end

  // Next state and state-decoded request outputs.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_IF: begin
        // Reset parks the FSM in IF; keep the fetch request quiet until reset is released.
        imem_req = rst_n;
        if (imem_valid) state_nxt = S_ID;
      end
      S_ID: state_nxt = (ir == HALT_WORD) ? S_HALT : S_EX;
      S_EX: begin
        illegal = ~ex_legal;
        if (!ex_legal || ex_branch) state_nxt = S_IF;
        else if (ex_mem)            state_nxt = S_MEM;
        else                        state_nxt = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ex_store;
        if (dmem_valid) state_nxt = ex_store ? S_IF : S_WB;
      end
      S_WB:    state_nxt = S_IF;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IF;
    else        state <= state_nxt;
  end

  assign imem_addr  = pc[ADDR_W-1:0];
  assign dmem_addr  = alu_out[ADDR_W-1:0];
  assign dmem_wdata = b_q;

  // An instruction retires on the edge that returns the FSM to IF from any other state.
  logic retire;
  assign retire = (state != S_IF) && (state_nxt == S_IF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      ir          <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_out     <= '0;
      mdr         <= '0;
      done        <= 1'b0;
      clock_count <= '0;
      instr_count <= '0;
      for (int i = 0; i < 32; i++)
        regs[i] <= (REG_INIT != 0) ? 32'(i) : 32'd0;
    end else begin
      case (state)
        S_IF: if (imem_valid) begin
          ir <= imem_rdata;
          pc <= pc + 32'd4;
        end
        S_ID: begin
          a_q <= (rs1 == 5'd0) ? 32'd0 : regs[rs1];
          b_q <= (rs2 == 5'd0) ? 32'd0 : regs[rs2];
          if (state_nxt == S_HALT) done <= 1'b1;
        end
        S_EX: begin
          alu_out <= ex_val;
          if (ex_branch && ex_taken) pc <= pc_ir + imm_b;
          if (ex_jal)                pc <= pc_ir + imm_j;
        end
        S_MEM: if (dmem_valid && !ex_store) mdr <= dmem_rdata;
        S_WB: if (rd != 5'd0) regs[rd] <= (opcode == OP_LOAD) ? mdr : alu_out;
        default: ;
      endcase
      if (state != S_HALT && clock_count != '1) clock_count <= clock_count + CNT_W'(1);
      if (retire && instr_count != '1)          instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule
